raifes_hasti_arbiter2: RTL

Two-master to one-slave HASTI (AHB-lite) arbiter that shares a single peripheral port, such as raifes_gpio or another slave, between the core data port (m0) and a second requester (m1, debug/DMA).
- Each master has a one-deep capture register for its address phase.
- The arbiter replays captured transfers to the slave one at a time, with no address/data overlap.
- It stalls each master through its own hready until that master's transfer completes.
- It sits between the masters and the peripheral decode.

---
 rtl/raifes_hasti_arbiter2.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/raifes_hasti_arbiter2.sv
// Two-master HASTI arbiter: each master's address phase is captured and replayed to one shared slave.
// Latency: 3 cycles per transfer (ARB_IDLE, ARB_ADDR, ARB_DATA) plus slave wait states.
// Backpressure: mN_hready is low while N's captured transfer is pending; s_hready stalls the replay.
module raifes_hasti_arbiter2 #(
    parameter int ARB_MODE          = 0,
    parameter int LOCK_EN           = 1,
    parameter int HASTI_ADDR_WIDTH  = 32,
    parameter int HASTI_BUS_WIDTH   = 32,
    parameter int HASTI_SIZE_WIDTH  = 3,
    parameter int HASTI_BURST_WIDTH = 3,
    parameter int HASTI_PROT_WIDTH  = 4,
    parameter int HASTI_TRANS_WIDTH = 2,
    parameter int HASTI_RESP_WIDTH  = 1
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [HASTI_ADDR_WIDTH-1:0]  m0_haddr,
    input  logic                         m0_hwrite,
    input  logic [HASTI_SIZE_WIDTH-1:0]  m0_hsize,
    input  logic [HASTI_BURST_WIDTH-1:0] m0_hburst,
    input  logic                         m0_hmastlock,
    input  logic [HASTI_PROT_WIDTH-1:0]  m0_hprot,
    input  logic [HASTI_TRANS_WIDTH-1:0] m0_htrans,
    input  logic [HASTI_BUS_WIDTH-1:0]   m0_hwdata,
    output logic [HASTI_BUS_WIDTH-1:0]   m0_hrdata,
    output logic                         m0_hready,
    output logic [HASTI_RESP_WIDTH-1:0]  m0_hresp,

    input  logic [HASTI_ADDR_WIDTH-1:0]  m1_haddr,
    input  logic                         m1_hwrite,
    input  logic [HASTI_SIZE_WIDTH-1:0]  m1_hsize,
    input  logic [HASTI_BURST_WIDTH-1:0] m1_hburst,
    input  logic                         m1_hmastlock,
    input  logic [HASTI_PROT_WIDTH-1:0]  m1_hprot,
    input  logic [HASTI_TRANS_WIDTH-1:0] m1_htrans,
    input  logic [HASTI_BUS_WIDTH-1:0]   m1_hwdata,
    output logic [HASTI_BUS_WIDTH-1:0]   m1_hrdata,
    output logic                         m1_hready,
    output logic [HASTI_RESP_WIDTH-1:0]  m1_hresp,

    output logic [HASTI_ADDR_WIDTH-1:0]  s_haddr,
    output logic                         s_hwrite,
    output logic [HASTI_SIZE_WIDTH-1:0]  s_hsize,
    output logic [HASTI_BURST_WIDTH-1:0] s_hburst,
    output logic                         s_hmastlock,
    output logic [HASTI_PROT_WIDTH-1:0]  s_hprot,
    output logic [HASTI_TRANS_WIDTH-1:0] s_htrans,
    output logic [HASTI_BUS_WIDTH-1:0]   s_hwdata,
    input  logic [HASTI_BUS_WIDTH-1:0]   s_hrdata,
    input  logic                         s_hready,
    input  logic [HASTI_RESP_WIDTH-1:0]  s_hresp
);

    localparam logic [HASTI_TRANS_WIDTH-1:0] TR_IDLE   = '0;
    localparam logic [HASTI_TRANS_WIDTH-1:0] TR_NONSEQ = HASTI_TRANS_WIDTH'(2);
    localparam logic [HASTI_TRANS_WIDTH-1:0] TR_SEQ    = HASTI_TRANS_WIDTH'(3);

    typedef struct packed {
        logic [HASTI_ADDR_WIDTH-1:0]  addr;
        logic                         write;
        logic [HASTI_SIZE_WIDTH-1:0]  size;
        logic [HASTI_BURST_WIDTH-1:0] burst;
        logic                         mastlock;
        logic [HASTI_PROT_WIDTH-1:0]  prot;
    } cap_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} state_t;

    state_t                         state;
    cap_t                           cap0, cap1, in0, in1, s_ctrl;
    logic [HASTI_TRANS_WIDTH-1:0]   s_trans_q;
    logic                           pend0, pend1;
    logic                           owner, last_grant, lock;
    logic                           done, done0, done1;
    logic                           cap_en0, cap_en1;
    logic                           grant_vld, winner;

    assign in0 = {m0_haddr, m0_hwrite, m0_hsize, m0_hburst, m0_hmastlock, m0_hprot};
    assign in1 = {m1_haddr, m1_hwrite, m1_hsize, m1_hburst, m1_hmastlock, m1_hprot};

    // Completion cycle: the owner's hready rises so it can issue back-to-back.
    assign done  = (state == ARB_DATA) && s_hready;
    assign done0 = done && !owner;
    assign done1 = done && owner;

    assign m0_hready = !pend0 || done0;
    assign m1_hready = !pend1 || done1;
    assign cap_en0   = m0_hready && ((m0_htrans == TR_NONSEQ) || (m0_htrans == TR_SEQ));
    assign cap_en1   = m1_hready && ((m1_htrans == TR_NONSEQ) || (m1_htrans == TR_SEQ));

    assign m0_hrdata = done0 ? s_hrdata : '0;
    assign m1_hrdata = done1 ? s_hrdata : '0;
    assign m0_hresp  = done0 ? s_hresp  : '0;
    assign m1_hresp  = done1 ? s_hresp  : '0;

    assign s_haddr     = s_ctrl.addr;
    assign s_hwrite    = s_ctrl.write;
    assign s_hsize     = s_ctrl.size;
    assign s_hburst    = s_ctrl.burst;
    assign s_hmastlock = s_ctrl.mastlock;
    assign s_hprot     = s_ctrl.prot;
    assign s_htrans    = s_trans_q;
    assign s_hwdata    = (state != ARB_DATA) ? '0 : (owner ? m1_hwdata : m0_hwdata);

    always_comb begin
        grant_vld = 1'b0;
        winner    = 1'b0;
        if (lock) begin
            grant_vld = owner ? pend1 : pend0;
            winner    = owner;
        end else if (pend0 && pend1) begin
            grant_vld = 1'b1;
            winner    = (ARB_MODE != 0) ? 1'b0 : !last_grant;
        end else if (pend0 || pend1) begin
            grant_vld = 1'b1;
            winner    = pend1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            cap0       <= '0;
            cap1       <= '0;
            pend0      <= 1'b0;
            pend1      <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lock       <= 1'b0;
            s_ctrl     <= '0;
            s_trans_q  <= TR_IDLE;
        end else begin
            if (cap_en0) begin
                cap0  <= in0;
                pend0 <= 1'b1;
            end else if (done0) begin
                pend0 <= 1'b0;
            end
            if (cap_en1) begin
                cap1  <= in1;
                pend1 <= 1'b1;
            end else if (done1) begin
                pend1 <= 1'b0;
            end

            case (state)
                ARB_IDLE: begin
                    if (grant_vld) begin
                        owner      <= winner;
                        last_grant <= winner;
                        s_ctrl     <= winner ? cap1 : cap0;
                        s_trans_q  <= TR_NONSEQ;
                        state      <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (s_hready) begin
                        s_trans_q <= TR_IDLE;
                        state     <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    // Address/control stay valid through the data phase for slaves that resample.
                    if (s_hready) begin
                        lock   <= (LOCK_EN != 0) && s_ctrl.mastlock;
                        s_ctrl <= '0;
                        state  <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
